time_set_ctrl: RTL and testbench

Digit editor for the alarm clock's set mode. It turns debounced `mode`/`up`/`next` button levels into single-cycle `set_*` load pulses and a shared `new_val` bus, driving the `set`/`new_val` inputs of the four time-digit registers. It edits hours-tens, hours-ones, minutes-tens and minutes-ones in that order, in 24-hour format. It reads the registers' current values so editing starts from the displayed time.

---
 rtl/alarm_pkg.sv | 58 +++++
 rtl/btn_repeat.sv | 60 ++++++
 rtl/time_set_ctrl.sv | 135 +++++++++++++
 tb/tb_time_set_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and digit limits for the alarm clock time-set editor.
// Holds the edit FSM encoding plus the helpers that wrap each digit.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ED_HT = 3'd1,
    ST_ED_HO = 3'd2,
    ST_ED_MT = 3'd3,
    ST_ED_MO = 3'd4,
    ST_FIXUP = 3'd5
  } edit_state_t;

  localparam logic [1:0] DIG_HT = 2'd0;
  localparam logic [1:0] DIG_HO = 2'd1;
  localparam logic [1:0] DIG_MT = 2'd2;
  localparam logic [1:0] DIG_MO = 2'd3;

  localparam logic [3:0] HR_T_MAX    = 4'd2;
  localparam logic [3:0] HR_O_MAX    = 4'd9;
  localparam logic [3:0] HR_O_MAX_20 = 4'd3;
  localparam logic [3:0] MIN_T_MAX   = 4'd5;
  localparam logic [3:0] MIN_O_MAX   = 4'd9;

  // Upper bound of a digit; hours-ones shrinks to 0..3 in the 20s.
  function automatic logic [3:0] digit_max(input logic [1:0] idx, input logic [3:0] hr_t);
    case (idx)
      DIG_HT:  return HR_T_MAX;
      DIG_HO:  return (hr_t == HR_T_MAX) ? HR_O_MAX_20 : HR_O_MAX;
      DIG_MT:  return MIN_T_MAX;
      default: return MIN_O_MAX;
    endcase
  endfunction

  // ">=" rather than "==" so out-of-range loaded values also wrap to 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

  function automatic edit_state_t digit_state(input logic [1:0] idx);
    case (idx)
      DIG_HT:  return ST_ED_HT;
      DIG_HO:  return ST_ED_HO;
      DIG_MT:  return ST_ED_MT;
      default: return ST_ED_MO;
    endcase
  endfunction

  function automatic logic [1:0] state_digit(input edit_state_t st);
    case (st)
      ST_ED_HO: return DIG_HO;
      ST_ED_MT: return DIG_MT;
      ST_ED_MO: return DIG_MO;
      default:  return DIG_HT;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector for one debounced button, with an optional
// hold counter that emits auto-repeat ticks while the button stays down.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_edge,
  output logic o_tick
);

  logic r_prev;

  // Loaded with the live level even in reset, so a button already held
  // while reset is released never looks like a fresh press.
  always_ff @(posedge clk) begin
    r_prev <= i_btn;
  end

  assign o_edge = i_btn & ~r_prev;

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int unsigned LIM = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int CW = $clog2(LIM + 1);

      logic [CW-1:0] r_cnt;
      logic          r_rate;
      logic [CW-1:0] w_lim;

      // r_cnt is the number of cycles since the press (0 = not tracking).
      assign w_lim  = r_rate ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
      assign o_tick = i_btn & (r_cnt != '0) & (r_cnt == w_lim);

      always_ff @(posedge clk) begin
        if (reset || i_clr || !i_btn) begin
          r_cnt  <= '0;
          r_rate <= 1'b0;
        end else if (o_edge) begin
          r_cnt  <= CW'(1);
          r_rate <= 1'b0;
        end else if (o_tick) begin
          r_cnt  <= CW'(1);
          r_rate <= 1'b1;
        end else if (r_cnt != '0) begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end
    end else begin : g_norep
      logic w_unused;
      assign w_unused = ^{i_clr, reset};
      assign o_tick   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode digit editor: turns mode/up/next presses into one-cycle load
// strobes for the four time-digit registers, editing from the shown time.
module time_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned TIMEOUT      = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_next,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_o,
  output logic [3:0] new_val,
  output logic       set_hr_t,
  output logic       set_hr_o,
  output logic       set_min_t,
  output logic       set_min_o,
  output logic       editing,
  output logic [1:0] digit_sel
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  edit_state_t     r_state;
  logic [3:0][3:0] r_sh;
  logic [3:0]      r_set;
  logic [3:0]      r_new_val;
  logic            r_editing;
  logic [1:0]      r_digit_sel;
  logic [TW-1:0]   r_to;

  logic       w_mode, w_up, w_next, w_tick;
  logic       w_mode_tick_unused, w_next_tick_unused;
  logic       w_in_ed, w_any_edge, w_inc, w_timeout, w_clr;
  logic [1:0] w_dig;
  logic [3:0] w_inc_val;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)) u_up (
    .clk(clk), .reset(reset), .i_btn(btn_up), .i_clr(w_clr),
    .o_edge(w_up), .o_tick(w_tick)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)) u_mode (
    .clk(clk), .reset(reset), .i_btn(btn_mode), .i_clr(1'b0),
    .o_edge(w_mode), .o_tick(w_mode_tick_unused)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)) u_next (
    .clk(clk), .reset(reset), .i_btn(btn_next), .i_clr(1'b0),
    .o_edge(w_next), .o_tick(w_next_tick_unused)
  );

  assign w_in_ed    = r_state inside {ST_ED_HT, ST_ED_HO, ST_ED_MT, ST_ED_MO};
  assign w_any_edge = w_mode | w_up | w_next;
  assign w_dig      = state_digit(r_state);
  assign w_inc      = w_in_ed & (w_up | w_tick);
  assign w_inc_val  = digit_inc(r_sh[w_dig], digit_max(w_dig, r_sh[DIG_HT]));
  // A pending repeat tick wins over timeout; the exit follows next cycle.
  assign w_timeout  = w_in_ed & (r_to == TO_MAX) & ~w_any_edge & ~w_tick;
  // Repeat restarts only from a fresh press once the digit or mode changes.
  assign w_clr      = (r_state == ST_IDLE) | (w_in_ed & (w_mode | w_next | w_timeout));

  always_ff @(posedge clk) begin
    if (reset || r_state == ST_IDLE || w_any_edge) r_to <= '0;
    else if (r_to != TO_MAX)                      r_to <= r_to + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sh        <= '0;
      r_set       <= '0;
      r_new_val   <= '0;
      r_editing   <= 1'b0;
      r_digit_sel <= DIG_HT;
    end else begin
      r_set     <= '0;
      r_new_val <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_mode) begin
            r_sh        <= {cur_min_o, cur_min_t, cur_hr_o, cur_hr_t};
            r_state     <= ST_ED_HT;
            r_editing   <= 1'b1;
            r_digit_sel <= DIG_HT;
          end
        end
        // Hours just became 2x with ones above 3: pull ones back into range.
        ST_FIXUP: begin
          r_sh[DIG_HO]  <= HR_O_MAX_20;
          r_set[DIG_HO] <= 1'b1;
          r_new_val     <= HR_O_MAX_20;
          r_state       <= ST_ED_HT;
        end
        default: begin
          if (w_mode || w_timeout) begin
            r_state     <= ST_IDLE;
            r_editing   <= 1'b0;
            r_digit_sel <= DIG_HT;
          end else if (w_next) begin
            r_digit_sel <= w_dig + 2'd1;
            if (w_dig == DIG_MO) begin
              r_state   <= ST_IDLE;
              r_editing <= 1'b0;
            end else begin
              r_state   <= digit_state(w_dig + 2'd1);
            end
          end else if (w_inc) begin
            r_sh[w_dig]  <= w_inc_val;
            r_set[w_dig] <= 1'b1;
            r_new_val    <= w_inc_val;
            if (w_dig == DIG_HT && w_inc_val == HR_T_MAX && r_sh[DIG_HO] > HR_O_MAX_20)
              r_state <= ST_FIXUP;
          end
        end
      endcase
    end
  end

  assign new_val   = r_new_val;
  assign set_hr_t  = r_set[DIG_HT];
  assign set_hr_o  = r_set[DIG_HO];
  assign set_min_t = r_set[DIG_MT];
  assign set_min_o = r_set[DIG_MO];
  assign editing   = r_editing;
  assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_time_set_ctrl;

  localparam int DLY = 8;
  localparam int RATE = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b1, btn_up = 1'b0, btn_next = 1'b0;
  logic [3:0] cur_hr_t = '0, cur_hr_o = '0, cur_min_t = '0, cur_min_o = '0;
  logic [3:0] new_val;
  logic       set_hr_t, set_hr_o, set_min_t, set_min_o, editing;
  logic [1:0] digit_sel;
  logic [3:0] w_set;

  int checks = 0;
  int failures = 0;

  time_set_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_next(btn_next),
    .cur_hr_t(cur_hr_t), .cur_hr_o(cur_hr_o), .cur_min_t(cur_min_t), .cur_min_o(cur_min_o),
    .new_val(new_val), .set_hr_t(set_hr_t), .set_hr_o(set_hr_o),
    .set_min_t(set_min_t), .set_min_o(set_min_o),
    .editing(editing), .digit_sel(digit_sel)
  );

  assign w_set = {set_min_o, set_min_t, set_hr_o, set_hr_t};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_dig: -1 when not editing, else digit under edit. m_hold: cycles since
  // the up press while held (-1 = not tracking). m_idle: edge-free edit cycles.
  int       m_dig = -1;
  bit       m_fix = 0;
  int       m_sh[4];
  bit       m_pm, m_pu, m_pn;
  int       m_hold = -1;
  int       m_idle = 0;
  bit       m_ok = 0;
  bit [3:0] e_set = '0;
  int       e_nv = 0;
  bit       e_edit = 0;
  int       e_sel = 0;

  function automatic int dmax(int d, int ht);
    case (d)
      0: return 2;
      1: return (ht == 2) ? 3 : 9;
      2: return 5;
      default: return 9;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit em, eu, en, tick, ed, any, tout;
    int k, v, d;
    e_set = '0;
    e_nv  = 0;
    if (reset) begin
      m_ok = 1; m_dig = -1; m_fix = 0; m_hold = -1; m_idle = 0;
      m_pm = btn_mode; m_pu = btn_up; m_pn = btn_next;
    end else begin
      em = btn_mode && !m_pm; eu = btn_up && !m_pu; en = btn_next && !m_pn;
      m_pm = btn_mode; m_pu = btn_up; m_pn = btn_next;
      any = em || eu || en;
      ed  = (m_dig >= 0) && !m_fix;
      if (eu) k = 0;
      else if (m_hold >= 0 && btn_up) k = m_hold + 1;
      else k = -1;
      if (m_dig < 0) k = -1;
      tick = ed && k >= DLY && ((k - DLY) % RATE) == 0;
      if (any || m_dig < 0) m_idle = 0; else m_idle++;
      tout = ed && !tick && m_idle >= TO;
      if (m_fix) begin
        m_sh[1] = 3; e_set[1] = 1; e_nv = 3; m_fix = 0;
      end else if (m_dig < 0) begin
        if (em) begin
          m_sh[0] = cur_hr_t; m_sh[1] = cur_hr_o; m_sh[2] = cur_min_t; m_sh[3] = cur_min_o;
          m_dig = 0;
        end
      end else if (em) m_dig = -1;
      else if (en) m_dig = (m_dig == 3) ? -1 : m_dig + 1;
      else if (eu || tick) begin
        d = m_dig;
        v = (m_sh[d] >= dmax(d, m_sh[0])) ? 0 : m_sh[d] + 1;
        m_sh[d] = v; e_set[d] = 1; e_nv = v;
        if (d == 0 && v == 2 && m_sh[1] > 3) m_fix = 1;
      end else if (tout) m_dig = -1;
      if (ed && (em || en || tout)) k = -1;
      m_hold = k;
    end
    e_edit = (m_dig >= 0);
    e_sel  = (m_dig < 0) ? 0 : m_dig;
  end

  always @(posedge clk) begin : compare
    #1;
    if (m_ok) begin
      chk("cycle_ctrl", {editing, digit_sel, w_set}, {e_edit, 2'(e_sel), e_set});
      if (e_set != '0) chk("cycle_new_val", new_val, e_nv);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit m, input bit u, input bit n);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_next = n;
    @(posedge clk);
    #2;
  endtask

  task automatic set_cur(input int a, input int b, input int c, input int d);
    cur_hr_t = 4'(a); cur_hr_o = 4'(b); cur_min_t = 4'(c); cur_min_o = 4'(d);
  endtask

  int pk[$];
  int pv[$];
  int first_idle;
  int exp_k[4] = '{0, 8, 12, 16};
  int exp_v[4] = '{1, 2, 3, 4};

  initial begin
    // reset with mode held: no phantom edge afterwards
    repeat (3) drive(1, 0, 0);
    reset = 1'b0;
    drive(1, 0, 0);
    chk("rst_editing", editing, 0);
    chk("rst_set", w_set, 0);
    chk("rst_new_val", new_val, 0);
    chk("rst_digit_sel", digit_sel, 0);
    drive(0, 0, 0);

    // enter at 17:45, three up presses on hours-tens (first forces fixup)
    set_cur(1, 7, 4, 5);
    drive(1, 0, 0);
    chk("enter_editing", editing, 1);
    chk("enter_sel", digit_sel, 0);
    chk("enter_set", w_set, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); chk("ht_up1_set", w_set, 4'b0001); chk("ht_up1_val", new_val, 2);
    drive(0, 0, 0); chk("ht_fix_set", w_set, 4'b0010); chk("ht_fix_val", new_val, 3);
    drive(0, 1, 0); chk("ht_up2_set", w_set, 4'b0001); chk("ht_up2_val", new_val, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); chk("ht_up3_val", new_val, 1);
    drive(0, 0, 0);
    drive(1, 0, 0); chk("exit_mode", editing, 0);
    drive(0, 0, 0);

    // 18:59: fixup then walk to minutes-tens, same-cycle up+next
    set_cur(1, 8, 5, 9);
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); chk("fx_ht_val", new_val, 2);
    drive(0, 0, 0); chk("fx_ho_set", w_set, 4'b0010); chk("fx_ho_val", new_val, 3);
    chk("fx_back_ht", digit_sel, 0);
    drive(0, 0, 1); chk("next_sel1", digit_sel, 1);
    drive(0, 0, 0);
    drive(0, 1, 1); chk("upnext_sel", digit_sel, 2); chk("upnext_noset", w_set, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); chk("mt_wrap_set", w_set, 4'b0100); chk("mt_wrap_val", new_val, 0);
    drive(0, 0, 0);
    drive(0, 0, 1); chk("next_sel3", digit_sel, 3);
    drive(0, 0, 0);
    drive(0, 0, 1); chk("next_exit", editing, 0);
    drive(0, 0, 0);

    // auto-repeat on minutes-ones from 0
    set_cur(0, 0, 0, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    repeat (3) begin drive(0, 0, 1); drive(0, 0, 0); end
    chk("rep_sel", digit_sel, 3);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0);
      if (set_min_o) begin pk.push_back(k); pv.push_back(int'(new_val)); end
    end
    chk("rep_count", pk.size(), 4);
    for (int i = 0; i < pk.size() && i < 4; i++) begin
      chk("rep_cycle", pk[i], exp_k[i]);
      chk("rep_val", pv[i], exp_v[i]);
    end
    drive(0, 0, 0);
    chk("rep_timed_out", editing, 0);

    // reset right after a fixup-triggering press cancels the fixup
    set_cur(1, 9, 0, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); chk("rstfx_ht", w_set, 4'b0001);
    reset = 1'b1;
    drive(0, 0, 0);
    chk("rstfx_set", w_set, 0); chk("rstfx_edit", editing, 0);
    chk("rstfx_val", new_val, 0); chk("rstfx_sel", digit_sel, 0);
    reset = 1'b0;
    drive(0, 0, 0); chk("rstfx_noho", w_set, 0);

    // idle timeout
    drive(1, 0, 0); chk("to_enter", editing, 1);
    first_idle = -1;
    for (int k = 1; k <= 40 && first_idle < 0; k++) begin
      drive(0, 0, 0);
      if (!editing) first_idle = k;
    end
    chk("to_cycle", first_idle, TO);

    // out-of-range / 20s wraps from 23:7F
    set_cur(2, 3, 7, 15);
    drive(1, 0, 0); drive(0, 0, 0);
    drive(0, 0, 1); drive(0, 0, 0);
    drive(0, 1, 0); chk("ho20_wrap_set", w_set, 4'b0010); chk("ho20_wrap_val", new_val, 0);
    drive(0, 0, 0);
    drive(0, 0, 1); drive(0, 0, 0);
    drive(0, 1, 0); chk("mt_oor_val", new_val, 0);
    drive(0, 0, 0);
    drive(0, 0, 1); drive(0, 0, 0);
    drive(0, 1, 0); chk("mo_oor_val", new_val, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); chk("mo_next_val", new_val, 1);
    drive(0, 0, 0);
    drive(1, 0, 0); drive(0, 0, 0);

    // mode beats next in the same cycle
    drive(1, 0, 0); drive(0, 0, 0);
    drive(1, 0, 1); chk("prio_editing", editing, 0); chk("prio_sel", digit_sel, 0);
    drive(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
